// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin arbitration of buffered writebacks onto the single register file write port
module rf_write_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          hold,
    output logic                          rf_write,
    output logic [ADDR_WIDTH-1:0]         rf_addr,
    output logic [DATA_WIDTH-1:0]         rf_data,
    output logic [(1<<ADDR_WIDTH)-1:0]    pending_mask,
    output logic [1:0]                    grant_id
);
    logic [NUM_REQ-1:0]    occ;
    logic [ADDR_WIDTH-1:0] baddr [NUM_REQ];
    logic [DATA_WIDTH-1:0] bdata [NUM_REQ];
    logic [1:0]            ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [1:0]            gidx;
    logic                  found;
    logic [1:0]            idx;

    // scan occupied buffers starting one past the last winner, wrapping explicitly
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (idx == 2'(NUM_REQ-1)) ? 2'd0 : idx + 2'd1;
            if (!found && !hold && occ[idx]) begin
                grant[idx] = 1'b1;
                gidx       = idx;
                found      = 1'b1;
            end
        end
    end

    assign req_ready = ~occ | grant;

    // registers with a buffered or outgoing write are marked pending
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (occ[i]) pending_mask[baddr[i]] = 1'b1;
        if (rf_write) pending_mask[rf_addr] = 1'b1;
    end

    // buffer loads, output stage and pointer advance
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ      <= '0;
            rf_write <= 1'b0;
            rf_addr  <= '0;
            rf_data  <= '0;
            grant_id <= '0;
            ptr      <= 2'(NUM_REQ-1);
        end else begin
            rf_write <= found;
            if (found) begin
                rf_addr  <= baddr[gidx];
                rf_data  <= bdata[gidx];
                grant_id <= gidx;
                ptr      <= gidx;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    occ[i]   <= 1'b1;
                    baddr[i] <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                    bdata[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end else if (grant[i]) begin
                    occ[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: randomized and directed checks against a queue-level arbitration model
module tb_rf_write_arbiter;
    localparam int N = 3, DW = 16, AW = 2;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              hold = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*AW-1:0]   req_addr = '0;
    logic [N*DW-1:0]   req_data = '0;
    logic [N-1:0]      req_ready;
    logic              rf_write;
    logic [AW-1:0]     rf_addr;
    logic [DW-1:0]     rf_data;
    logic [(1<<AW)-1:0] pending_mask;
    logic [1:0]        grant_id;

    rf_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .hold(hold), .rf_write(rf_write),
        .rf_addr(rf_addr), .rf_data(rf_data), .pending_mask(pending_mask), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int m_q_addr [N][$];
    int m_q_data [N][$];
    int m_last, m_waddr, m_wdata, m_gid;
    bit m_wr;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_q_addr[i].delete();
            m_q_data[i].delete();
        end
        m_last = N - 1;
        m_wr = 0;
        m_waddr = 0;
        m_wdata = 0;
        m_gid = 0;
    endtask

    function automatic int pick();
        for (int k = 1; k <= N; k++) begin
            int c = (m_last + k) % N;
            if (!hold && m_q_addr[c].size() != 0) return c;
        end
        return -1;
    endfunction

    task automatic step();
        int g, pm;
        bit [N-1:0] rdy;
        #1;
        g = pick();
        for (int i = 0; i < N; i++) rdy[i] = (m_q_addr[i].size() == 0) || (g == i);
        check("req_ready", int'(req_ready), int'(rdy));
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            m_wr = (g >= 0);
            if (g >= 0) begin
                m_waddr = m_q_addr[g].pop_front();
                m_wdata = m_q_data[g].pop_front();
                m_gid = g;
                m_last = g;
            end
            for (int i = 0; i < N; i++)
                if (req_valid[i] && rdy[i]) begin
                    m_q_addr[i].push_back(int'(req_addr[i*AW +: AW]));
                    m_q_data[i].push_back(int'(req_data[i*DW +: DW]));
                end
        end
        @(negedge clk);
        check("rf_write", int'(rf_write), int'(m_wr));
        check("rf_addr", int'(rf_addr), m_waddr);
        check("rf_data", int'(rf_data), m_wdata);
        if (m_wr) check("grant_id", int'(grant_id), m_gid);
        pm = 0;
        for (int i = 0; i < N; i++) if (m_q_addr[i].size() != 0) pm |= 1 << m_q_addr[i][0];
        if (m_wr) pm |= 1 << m_waddr;
        check("pending_mask", int'(pending_mask), pm);
    endtask

    task automatic drive(input bit [N-1:0] v, input bit h, input bit rn);
        req_valid = v;
        hold = h;
        reset_n = rn;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = AW'($urandom_range(0, (1 << AW) - 1));
            req_data[i*DW +: DW] = DW'($urandom);
        end
    endtask

    initial begin
        @(posedge clk);
        @(negedge clk);
        model_reset();
        step();
        // single write, req 1 -> r2 = 0xBEEF
        reset_n = 1'b1;
        req_valid = 3'b010;
        req_addr = '0;
        req_addr[1*AW +: AW] = 2'd2;
        req_data[1*DW +: DW] = 16'hBEEF;
        step();
        check("single_mask", int'(pending_mask), 4);
        req_valid = '0;
        step();
        check("single_data", int'(rf_data), 16'hBEEF);
        check("single_id", int'(grant_id), 1);
        step();
        check("single_drain", int'(pending_mask), 0);
        // all three at once, addresses 0/1/3
        req_valid = 3'b111;
        req_addr = {2'd3, 2'd1, 2'd0};
        step();
        req_valid = '0;
        repeat (4) step();
        // requester 0 streams
        for (int n = 0; n < 8; n++) begin
            drive(3'b001, 0, 1);
            step();
        end
        drive(3'b000, 0, 1);
        repeat (2) step();
        // contention between 0 and 2
        for (int n = 0; n < 10; n++) begin
            drive(3'b101, 0, 1);
            step();
        end
        drive(3'b000, 0, 1);
        repeat (3) step();
        // hold with buffers 0 and 1 occupied, 2 accepts while frozen
        drive(3'b011, 1, 1);
        step();
        drive(3'b100, 1, 1);
        step();
        drive(3'b000, 1, 1);
        repeat (3) step();
        drive(3'b000, 0, 1);
        repeat (4) step();
        // reset mid-operation with everything full
        drive(3'b111, 0, 1);
        repeat (2) step();
        drive(3'b111, 0, 0);
        step();
        drive(3'b000, 0, 1);
        repeat (4) step();
        // random traffic
        for (int n = 0; n < 3000; n++) begin
            drive(N'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 63) != 0));
            step();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
